fu_cdb_buffer: RTL and testbench

FU_CDB_BUFFER -- requirements
Module: fu_cdb_buffer

---
 rtl/fu_cdb_buffer_if.sv | 27 ++
 rtl/fu_cdb_buffer.sv | 110 +++++++++++
 tb/tb_fu_cdb_buffer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/fu_cdb_buffer_if.sv
// Result handshake between a functional-unit pipeline, its CDB buffer and the
// CDB arbiter: a push side (in_*) and a broadcast side (done/ack).
interface fu_cdb_buffer_if #(
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic [TAG_W-1:0]  in_rob_tag;
  logic [DATA_W-1:0] in_v;
  logic              in_ready;
  logic              done;
  logic [TAG_W-1:0]  rob_tag;
  logic [DATA_W-1:0] v;
  logic              ack;

  // Environment side: FU pipeline pushes results, arbiter grants the CDB.
  modport master (
    output in_valid, in_rob_tag, in_v, ack,
    input  in_ready, done, rob_tag, v
  );

  // Buffer side.
  modport slave (
    input  in_valid, in_rob_tag, in_v, ack,
    output in_ready, done, rob_tag, v
  );
endinterface

// File: rtl/fu_cdb_buffer.sv
// Per-FU result buffer in front of the common data bus. A circular FIFO keeps
// completed results in arrival order and presents the oldest one to the CDB
// arbiter with a level-sensitive done/ack handshake.
module fu_cdb_buffer #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  fu_cdb_buffer_if.slave           bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow_err
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [TAG_W-1:0]  tag_mem_r  [DEPTH];
  logic [DATA_W-1:0] data_mem_r [DEPTH];

  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] count_r;
  logic             overflow_err_r;

  logic [PTR_W-1:0] head_nxt_s;
  logic [PTR_W-1:0] tail_nxt_s;
  logic [CNT_W-1:0] count_nxt_s;
  logic             full_s;
  logic             empty_s;
  logic             push_s;
  logic             pop_s;
  logic             overflow_s;

  // Status depends on registered count only, so ack never reaches in_ready.
  assign full_s     = (count_r == FULL_CNT);
  assign empty_s    = (count_r == {CNT_W{1'b0}});
  assign push_s     = bus.in_valid && !full_s;
  assign pop_s      = !empty_s && bus.ack;
  assign overflow_s = bus.in_valid && full_s;

  // Head entry drives the CDB directly; no output register, no bypass.
  assign bus.in_ready = !full_s;
  assign bus.done     = !empty_s;
  assign bus.rob_tag  = tag_mem_r[head_r];
  assign bus.v        = data_mem_r[head_r];
  assign count        = count_r;
  assign overflow_err = overflow_err_r;

  // Next pointer and occupancy values from this cycle's push/pop decision.
  always_comb begin
    head_nxt_s  = head_r;
    tail_nxt_s  = tail_r;
    count_nxt_s = count_r;
    if (pop_s) begin
      head_nxt_s = head_r + PTR_W'(1);
    end else begin
      head_nxt_s = head_r;
    end
    if (push_s) begin
      tail_nxt_s = tail_r + PTR_W'(1);
    end else begin
      tail_nxt_s = tail_r;
    end
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointer/count state; reset and flush both empty the buffer and win over
  // any handshake in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else begin
      head_r  <= head_nxt_s;
      tail_r  <= tail_nxt_s;
      count_r <= count_nxt_s;
    end
  end

  // Sticky overflow flag; only reset clears it, a flush keeps the history.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_err_r <= 1'b0;
    end else if (overflow_s) begin
      overflow_err_r <= 1'b1;
    end else begin
      overflow_err_r <= overflow_err_r;
    end
  end

  // Entry storage is not reset; contents are only meaningful while counted.
  always_ff @(posedge clock) begin
    if (push_s) begin
      tag_mem_r[tail_r]  <= bus.in_rob_tag;
      data_mem_r[tail_r] <= bus.in_v;
    end
  end
endmodule

// File: tb/tb_fu_cdb_buffer.sv
// Directed self-checking bench for fu_cdb_buffer (DEPTH=4, TAG_W=5, DATA_W=32).
module tb_fu_cdb_buffer;
  logic        clock = 1'b0;
  logic        reset;
  logic        clear;
  logic [2:0]  count;
  logic        overflow_err;

  int passed = 0;
  int total  = 0;

  typedef struct packed {
    logic [4:0]  tag;
    logic [31:0] val;
  } entry_t;

  entry_t model_q[$];
  logic   model_ovf;

  fu_cdb_buffer_if #(.TAG_W(5), .DATA_W(32)) bus ();

  fu_cdb_buffer #(.DEPTH(4), .TAG_W(5), .DATA_W(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .clear        (clear),
    .bus          (bus),
    .count        (count),
    .overflow_err (overflow_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [4:0] t, input logic [31:0] val, input logic a);
    bus.in_valid   = iv;
    bus.in_rob_tag = t;
    bus.in_v       = val;
    bus.ack        = a;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    clear = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_count", 64'(count), 64'd0);
    check("rst_ovf", 64'(overflow_err), 64'd0);

    // Single push, held for several cycles without ack, then one ack.
    drive(1'b1, 5'd3, 32'hAA, 1'b0);
    check("no_bypass_done", 64'(bus.done), 64'd0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    check("push1_done", 64'(bus.done), 64'd1);
    check("push1_tag", 64'(bus.rob_tag), 64'd3);
    check("push1_v", 64'(bus.v), 64'hAA);
    check("push1_count", 64'(count), 64'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_done", 64'(bus.done), 64'd1);
      check("hold_tag", 64'(bus.rob_tag), 64'd3);
      check("hold_v", 64'(bus.v), 64'hAA);
    end
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    check("pop1_done", 64'(bus.done), 64'd0);
    check("pop1_count", 64'(count), 64'd0);

    // Fill, overflow attempt, then drain in order.
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 5'(i), 32'(i * 16), 1'b0);
      tick();
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    check("full_count", 64'(count), 64'd4);
    check("full_in_ready", 64'(bus.in_ready), 64'd0);
    check("full_ovf_pre", 64'(overflow_err), 64'd0);
    drive(1'b1, 5'd5, 32'h55, 1'b0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    check("ovf_set", 64'(overflow_err), 64'd1);
    check("ovf_count", 64'(count), 64'd4);
    bus.ack = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("drain_done", 64'(bus.done), 64'd1);
      check("drain_tag", 64'(bus.rob_tag), 64'(i));
      check("drain_v", 64'(bus.v), 64'(i * 16));
      tick();
    end
    bus.ack = 1'b0;
    check("drain_empty", 64'(bus.done), 64'd0);
    check("drain_count", 64'(count), 64'd0);

    // Steady state at two entries: push and ack every cycle, pointers wrap.
    drive(1'b1, 5'd10, 32'd100, 1'b0);
    tick();
    drive(1'b1, 5'd11, 32'd101, 1'b0);
    tick();
    check("steady_count0", 64'(count), 64'd2);
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 5'(12 + k), 32'(102 + k), 1'b1);
      check("steady_tag", 64'(bus.rob_tag), 64'(10 + k));
      check("steady_v", 64'(bus.v), 64'(100 + k));
      tick();
      check("steady_count", 64'(count), 64'd2);
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    check("steady_head", 64'(bus.rob_tag), 64'd20);

    // Reach three entries, then flush with push and ack both active.
    drive(1'b1, 5'd30, 32'd300, 1'b0);
    tick();
    check("pre_clear_count", 64'(count), 64'd3);
    drive(1'b1, 5'd31, 32'd301, 1'b1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    check("clear_count", 64'(count), 64'd0);
    check("clear_done", 64'(bus.done), 64'd0);
    check("clear_in_ready", 64'(bus.in_ready), 64'd1);
    check("clear_ovf_kept", 64'(overflow_err), 64'd1);

    // Ack on an empty buffer is ignored.
    bus.ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_ack_count", 64'(count), 64'd0);
      check("idle_ack_done", 64'(bus.done), 64'd0);
    end
    drive(1'b1, 5'd7, 32'h77, 1'b0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    check("after_idle_done", 64'(bus.done), 64'd1);
    check("after_idle_tag", 64'(bus.rob_tag), 64'd7);
    check("after_idle_count", 64'(count), 64'd1);

    // Reset during an active handshake empties the buffer and clears overflow.
    bus.ack = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.ack = 1'b0;
    check("mid_rst_count", 64'(count), 64'd0);
    check("mid_rst_done", 64'(bus.done), 64'd0);
    check("mid_rst_ovf", 64'(overflow_err), 64'd0);

    // Mixed traffic against a queue model.
    model_ovf = 1'b0;
    for (int c = 0; c < 600; c++) begin
      logic        iv;
      logic        a;
      logic        do_pop;
      logic        do_push;
      entry_t      e;
      iv = 1'($urandom_range(0, 1));
      a  = 1'($urandom_range(0, 2) != 0);
      e.tag = 5'($urandom);
      e.val = $urandom;
      drive(iv, e.tag, e.val, a);
      check("mix_count", 64'(count), 64'(model_q.size()));
      check("mix_done", 64'(bus.done), 64'(model_q.size() != 0));
      if (model_q.size() != 0) begin
        check("mix_tag", 64'(bus.rob_tag), 64'(model_q[0].tag));
        check("mix_v", 64'(bus.v), 64'(model_q[0].val));
      end
      do_pop  = a && (model_q.size() != 0);
      do_push = iv && (model_q.size() < 4);
      if (iv && model_q.size() == 4) model_ovf = 1'b1;
      tick();
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back(e);
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    check("mix_ovf", 64'(overflow_err), 64'(model_ovf));
    check("mix_final_count", 64'(count), 64'(model_q.size()));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
